hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath.
- Detects load-use hazards and generates the ID/EX bubble request (memBubble) that drives the stage-2 control-zeroing mux.
- Also stalls PC and IF/ID, flushes IF/ID on taken branches and jumps, and sequences multi-cycle stalls while the mult/div unit in EX is busy.
- Sits beside the ID stage; purely a sequencer, holds no datapath state.

Parameters:
- MD_LATENCY, 4, total EX cycles of a mult/div op; stall cycles = MD_LATENCY-1; legal range 1..15.
- CNT_W, 4, width of the mult/div stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- idex_memRead  input  1  instruction in EX is a load.
- idex_rt  input  5  load destination register in EX.
- idex_md  input  1  mult/div instruction entered EX this cycle.
- ifid_rs  input  5  rs of instruction in ID.
- ifid_rt  input  5  rt of instruction in ID.
- ifid_usesRt  input  1  instruction in ID reads rt (R-type, store, beq/bne).
- branchTaken  input  1  branch in ID resolved taken.
- jump  input  1  j/jal/jr in ID.
- pcWrite  output  1  PC load enable.
- ifidWrite  output  1  IF/ID register load enable.
- ifidFlush  output  1  zero IF/ID on next edge.
- memBubble  output  1  select-zero for the stage-2 control mux (16-bit control word forced to 0).
- mdBusy  output  1  high while in MD_BUSY.

Behaviour:
- States: RUN, MD_BUSY. Reset → RUN, counter=0.
- Output values while rst is high: pcWrite=1, ifidWrite=1, ifidFlush=0, memBubble=0, mdBusy=0.
- Load-use hazard (combinational, RUN only):
  - luHaz = idex_memRead & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_usesRt & (idex_rt == ifid_rt))).
  - Same cycle as luHaz: pcWrite=0, ifidWrite=0, memBubble=1.
  - Exactly one bubble per load; the next cycle re-evaluates against the new EX contents.
- Control transfer (RUN, no luHaz):
  - branchTaken or jump → ifidFlush=1 in the same cycle; pcWrite=1, ifidWrite=1.
  - Only one flush cycle; no bubble.
- Priority in RUN, high to low: luHaz > branchTaken/jump > none.
  - When luHaz=1, branchTaken and jump are ignored, since branch operands are stale; the branch re-resolves next cycle.
- Mult/div sequencing:
  - In RUN with idex_md=1 and MD_LATENCY>1: next state MD_BUSY, counter ← MD_LATENCY-1.
  - Any luHaz, flush or normal outputs in that same cycle still apply.
  - In MD_BUSY: pcWrite=0, ifidWrite=0, memBubble=1, ifidFlush=0, mdBusy=1. counter decrements each cycle.
  - When counter==1, next state RUN, counter ← 0. MD_BUSY therefore lasts exactly MD_LATENCY-1 cycles.
  - In MD_BUSY, idex_md, branchTaken, jump and luHaz are ignored; EX holds bubbles and ID is frozen.
  - MD_LATENCY==1: idex_md has no effect; the FSM stays in RUN.
- Back-to-back: an idex_md on the first RUN cycle after MD_BUSY starts a new MD_BUSY of full length.
- Reset mid-MD_BUSY: immediate return to RUN, counter=0, outputs to reset values without waiting for a clock edge.
- Register 0 never causes a hazard.
- Outputs are Moore in MD_BUSY and Mealy in RUN. There are no registered outputs other than the state and counter.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Enabled:
  - Adds outputs stallCnt[15:0] and flushCnt[15:0]. Both are 0 on reset.
  - stallCnt increments each cycle memBubble=1.
  - flushCnt increments each cycle ifidFlush=1.
  - Both saturate at 16'hFFFF.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles, with idex_md=1 held → pcWrite=1, ifidWrite=1, memBubble=0, ifidFlush=0, mdBusy=0; release → RUN.
- Load-use: idex_memRead=1, idex_rt=5'd8, ifid_rs=5'd8 → one cycle with memBubble=1, pcWrite=0, ifidWrite=0. Next cycle idex_memRead=0 → memBubble=0.
- Register-0 and rt cases:
  - idex_rt=0, ifid_rs=0, idex_memRead=1 → no stall.
  - idex_rt=9, ifid_rt=9, ifid_usesRt=0 → no stall.
  - Same with ifid_usesRt=1 → stall.
- Priority: luHaz and branchTaken=1 in the same cycle → memBubble=1, ifidFlush=0. Next cycle branchTaken=1 alone → ifidFlush=1, memBubble=0.
- Mult/div: MD_LATENCY=4, pulse idex_md for 1 cycle → mdBusy=1 and memBubble=1 for exactly 3 cycles, branchTaken=1 mid-busy ignored. Then RUN.
- Reset mid-MD_BUSY: assert rst on the 2nd busy cycle → mdBusy=0 immediately. After release, no residual stall. With HAZARD_STATS_EN set, stallCnt=0 after reset.

Source files
------------

// File: rtl/hazard_if.sv
// hazard_if: ID/EX hazard-controller signal bundle; stats ports appear only when HAZARD_STATS_EN is defined.
interface hazard_if;
  logic       idex_memRead;
  logic [4:0] idex_rt;
  logic       idex_md;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_usesRt;
  logic       branchTaken;
  logic       jump;
  logic       pcWrite;
  logic       ifidWrite;
  logic       ifidFlush;
  logic       memBubble;
  logic       mdBusy;
`ifdef HAZARD_STATS_EN
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;
  modport master (
    output idex_memRead, idex_rt, idex_md, ifid_rs, ifid_rt, ifid_usesRt, branchTaken, jump,
    input  pcWrite, ifidWrite, ifidFlush, memBubble, mdBusy, stallCnt, flushCnt
  );
  modport slave (
    input  idex_memRead, idex_rt, idex_md, ifid_rs, ifid_rt, ifid_usesRt, branchTaken, jump,
    output pcWrite, ifidWrite, ifidFlush, memBubble, mdBusy, stallCnt, flushCnt
  );
`else
  modport master (
    output idex_memRead, idex_rt, idex_md, ifid_rs, ifid_rt, ifid_usesRt, branchTaken, jump,
    input  pcWrite, ifidWrite, ifidFlush, memBubble, mdBusy
  );
  modport slave (
    input  idex_memRead, idex_rt, idex_md, ifid_rs, ifid_rt, ifid_usesRt, branchTaken, jump,
    output pcWrite, ifidWrite, ifidFlush, memBubble, mdBusy
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubbles, branch/jump flushes and mult/div stall sequencing for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hif
);
  typedef enum logic {RUN, MD_BUSY} state_t;
  localparam logic [CNT_W-1:0] MD_STALL = CNT_W'(MD_LATENCY - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_haz;
  logic             pc_write, ifid_write, ifid_flush, mem_bubble, md_busy;
  assign lu_haz = hif.idex_memRead && (hif.idex_rt != 5'd0) &&
                  ((hif.idex_rt == hif.ifid_rs) || (hif.ifid_usesRt && (hif.idex_rt == hif.ifid_rt)));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    mem_bubble = 1'b0;
    md_busy    = 1'b0;
    if (state_q == MD_BUSY) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      mem_bubble = 1'b1;
      md_busy    = 1'b1;
      state_d    = (cnt_q == CNT_W'(1)) ? RUN : MD_BUSY;
      cnt_d      = (cnt_q == CNT_W'(1)) ? '0 : cnt_q - 1'b1;
    end else begin
      // A stalled branch sees stale operands, so the load bubble wins and the branch re-resolves next cycle.
      pc_write   = !lu_haz;
      ifid_write = !lu_haz;
      mem_bubble = lu_haz;
      ifid_flush = !lu_haz && (hif.branchTaken || hif.jump);
      if (hif.idex_md && (MD_LATENCY > 1)) begin
        state_d = MD_BUSY;
        cnt_d   = MD_STALL;
      end
    end
    if (rst) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      mem_bubble = 1'b0;
      md_busy    = 1'b0;
    end
  end
  assign hif.pcWrite   = pc_write;
  assign hif.ifidWrite = ifid_write;
  assign hif.ifidFlush = ifid_flush;
  assign hif.memBubble = mem_bubble;
  assign hif.mdBusy    = md_busy;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (mem_bubble && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (ifid_flush && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign hif.stallCnt = stall_cnt_q;
  assign hif.flushCnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven checks of RUN-mode hazard decoding plus hand sequences for mult/div and reset.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  hazard_if hif ();
  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .hif(hif));
  always #5 clk = ~clk;
  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       br;
    logic       jmp;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[11];
  function automatic logic [4:0] outs();
    return {hif.pcWrite, hif.ifidWrite, hif.ifidFlush, hif.memBubble, hif.mdBusy};
  endfunction
  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = outs();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got pcw/ifw/flush/bubble/busy=%b expected %b", name, got, exp);
    end
  endtask
  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic br, input logic jmp, input logic md);
    hif.idex_memRead = mr;
    hif.idex_rt      = ert;
    hif.ifid_rs      = rs;
    hif.ifid_rt      = rt;
    hif.ifid_usesRt  = urt;
    hif.branchTaken  = br;
    hif.jump         = jmp;
    hif.idex_md      = md;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] BUSY  = 5'b00011;
  initial begin
    vecs[0]  = '{"idle",          1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[1]  = '{"lu_rs",         1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, STALL};
    vecs[2]  = '{"lu_cleared",    1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[3]  = '{"reg0",          1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, NORM};
    vecs[4]  = '{"rt_unused",     1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, NORM};
    vecs[5]  = '{"rt_used",       1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, STALL};
    vecs[6]  = '{"lu_over_br",    1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, STALL};
    vecs[7]  = '{"branch",        1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, FLUSH};
    vecs[8]  = '{"jump",          1'b0, 5'd0, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, FLUSH};
    vecs[9]  = '{"no_match",      1'b1, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, FLUSH};
    vecs[10] = '{"lu_over_jump",  1'b1, 5'd31, 5'd1, 5'd31, 1'b1, 1'b0, 1'b1, STALL};
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("reset_c0", NORM);
    step();
    chk("reset_c1", NORM);
    step();
    chk("reset_c2", NORM);
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if (hif.stallCnt !== 16'd0) begin
      n_err++;
      $display("FAIL stall_cnt_reset: got %0d expected 0", hif.stallCnt);
    end
`endif
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      drive(vecs[i].mr, vecs[i].ert, vecs[i].rs, vecs[i].rt, vecs[i].urt, vecs[i].br, vecs[i].jmp, 1'b0);
      #2;
      chk(vecs[i].name, vecs[i].exp);
    end
    for (int r = 0; r < 2; r++) begin
      step();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #2;
      chk($sformatf("md_issue%0d", r), NORM);
      for (int b = 0; b < 3; b++) begin
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, b == 1, 1'b0, 1'b0);
        #2;
        chk($sformatf("md_busy%0d_%0d", r, b), BUSY);
      end
    end
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("md_done_branch", FLUSH);
    step();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("md_with_lu", STALL);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("busy_before_rst", BUSY);
    step();
    chk("busy_second", BUSY);
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", NORM);
    @(negedge clk);
    chk("rst_held", NORM);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    #2;
    chk("post_rst_c0", NORM);
    step();
    chk("post_rst_c1", NORM);
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if (hif.stallCnt !== 16'd0) begin
      n_err++;
      $display("FAIL stall_cnt_after_rst: got %0d expected 0", hif.stallCnt);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
